// File: rtl/if_stage.sv
// Instruction-fetch stage: program counter, ROM chip enable and the IF/ID register.
// A redirect that arrives while the PC is held is remembered and applied on release.
module if_stage (
  input  logic        clk,
  input  logic        rst,
  input  logic [5:0]  stall,
  input  logic        branch_flag_i,
  input  logic [31:0] branch_target_address_i,
  input  logic [31:0] rom_data_i,
  output logic        rom_ce_o,
  output logic [31:0] pc_o,
  output logic [31:0] id_pc_o,
  output logic [31:0] id_inst_o
);

  logic        ce_q, ce_d;
  logic [31:0] pc_q, pc_d;
  logic        pend_valid_q, pend_valid_d;
  logic [31:0] pend_target_q, pend_target_d;
  logic [31:0] id_pc_q, id_pc_d;
  logic [31:0] id_inst_q, id_inst_d;

  // Chip enable, program counter and pending-redirect next state.
  always_comb begin
    ce_d          = 1'b1;
    pc_d          = pc_q;
    pend_valid_d  = pend_valid_q;
    pend_target_d = pend_target_q;
    if (!ce_q) begin
      pc_d         = 32'h0000_0000;
      pend_valid_d = 1'b0;
    end else if (stall[0]) begin
      pc_d = pc_q;
      if (branch_flag_i) begin
        pend_valid_d  = 1'b1;
        pend_target_d = branch_target_address_i;
      end else begin
        pend_valid_d  = pend_valid_q;
        pend_target_d = pend_target_q;
      end
    end else if (branch_flag_i) begin
      // A live redirect supersedes anything latched during the stall.
      pc_d         = branch_target_address_i;
      pend_valid_d = 1'b0;
    end else if (pend_valid_q) begin
      pc_d         = pend_target_q;
      pend_valid_d = 1'b0;
    end else begin
      pc_d = pc_q + 32'd4;
    end
  end

  // IF/ID register next state: bubble, hold or capture the fetched word.
  always_comb begin
    id_pc_d   = id_pc_q;
    id_inst_d = id_inst_q;
    if (stall[1]) begin
      if (stall[2]) begin
        id_pc_d   = id_pc_q;
        id_inst_d = id_inst_q;
      end else begin
        id_pc_d   = 32'h0000_0000;
        id_inst_d = 32'h0000_0000;
      end
    end else if (!ce_q) begin
      id_pc_d   = 32'h0000_0000;
      id_inst_d = 32'h0000_0000;
    end else begin
      id_pc_d   = pc_q;
      id_inst_d = rom_data_i;
    end
  end

  // State registers with asynchronous clear.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ce_q          <= 1'b0;
      pc_q          <= 32'h0000_0000;
      pend_valid_q  <= 1'b0;
      pend_target_q <= 32'h0000_0000;
      id_pc_q       <= 32'h0000_0000;
      id_inst_q     <= 32'h0000_0000;
    end else begin
      ce_q          <= ce_d;
      pc_q          <= pc_d;
      pend_valid_q  <= pend_valid_d;
      pend_target_q <= pend_target_d;
      id_pc_q       <= id_pc_d;
      id_inst_q     <= id_inst_d;
    end
  end

  assign rom_ce_o  = ce_q;
  assign pc_o      = pc_q;
  assign id_pc_o   = id_pc_q;
  assign id_inst_o = id_inst_q;

endmodule
